// File: rtl/and_reduce_pkg.sv
// and_reduce_pkg: shared constants and level-count helpers for the AND-reduce pipeline.
package and_reduce_pkg;
   localparam logic MODE_AND  = 1'b0;
   localparam logic MODE_NAND = 1'b1;
   function automatic int clog4(input int n);
      int r = 0;
      longint p = 1;
      while (p < n) begin
         p = p * 4;
         r++;
      end
      return r;
   endfunction
   function automatic int levels(input int n);
      return clog4(n) < 1 ? 1 : clog4(n);
   endfunction
endpackage

// File: rtl/and4_stage.sv
// and4_stage: one registered level of 4-input AND groups with valid/ready handshake.
module and4_stage
   import and_reduce_pkg::*;
#(
   parameter int GROUPS   = 1,
   parameter int CHANNELS = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_vld,
   output logic                         in_rdy,
   input  logic [CHANNELS*GROUPS*4-1:0] in_data,
   input  logic                         in_mode,
   output logic                         out_vld,
   input  logic                         out_rdy,
   output logic [CHANNELS*GROUPS-1:0]   out_data,
   output logic                         out_mode
);
   localparam int N = CHANNELS * GROUPS;
   logic [N-1:0] red;
   always_comb begin
      red = '0;
      for (int i = 0; i < N; i++) red[i] = &in_data[i*4 +: 4];
   end
   assign in_rdy = !out_vld | out_rdy;
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_data <= '0;
         out_mode <= MODE_AND;
      end else if (in_rdy) begin
         out_vld <= in_vld;
         if (in_vld) begin
            out_data <= red;
            out_mode <= in_mode;
         end
      end
   end
endmodule

// File: rtl/and_reduce_pipe.sv
// and_reduce_pipe: pipelined per-channel AND/NAND reduction tree.
// Define AND_REDUCE_PIPE_PERF_EN to build the saturating completed-beat counter.
module and_reduce_pipe
   import and_reduce_pkg::*;
#(
   parameter int NUM_IN   = 4,
   parameter int CHANNELS = 1
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       IN_VLD,
   output logic                       IN_RDY,
   input  logic [CHANNELS*NUM_IN-1:0] IN,
   input  logic                       MODE,
   output logic                       Q_VLD,
   input  logic                       Q_RDY,
   output logic [CHANNELS-1:0]        Q,
   output logic [15:0]                PERF_CNT
);
   localparam int LEVELS = levels(NUM_IN);
   localparam int PAD    = 4 ** LEVELS;
   // Unused leaves are tied high so they never affect the AND.
   logic [CHANNELS*PAD-1:0] pad;
   always_comb begin
      pad = '1;
      for (int c = 0; c < CHANNELS; c++) pad[c*PAD +: NUM_IN] = IN[c*NUM_IN +: NUM_IN];
   end
   for (genvar l = 0; l < LEVELS; l++) begin : g
      localparam int G = 4 ** (LEVELS - 1 - l);
      logic [CHANNELS*G*4-1:0] din;
      logic [CHANNELS*G-1:0]   dout;
      logic                    vin, mi, rin, vout, mout, rout;
      if (l == 0) begin : f
         assign din    = pad;
         assign vin    = IN_VLD;
         assign mi     = MODE;
         assign IN_RDY = rin;
      end else begin : m
         assign din = g[l-1].dout;
         assign vin = g[l-1].vout;
         assign mi  = g[l-1].mout;
      end
      if (l == LEVELS - 1) begin : t
         assign rout = Q_RDY;
      end else begin : n
         assign rout = g[l+1].rin;
      end
      and4_stage #(.GROUPS(G), .CHANNELS(CHANNELS)) u_stage (
         .clk(CLK), .rst(RST),
         .in_vld(vin), .in_rdy(rin), .in_data(din), .in_mode(mi),
         .out_vld(vout), .out_rdy(rout), .out_data(dout), .out_mode(mout)
      );
   end
   // Inversion is applied only on the registered final level, so Q stays stable under stall.
   assign Q_VLD = g[LEVELS-1].vout;
   assign Q     = g[LEVELS-1].mout == MODE_NAND ? ~g[LEVELS-1].dout : g[LEVELS-1].dout;
`ifdef AND_REDUCE_PIPE_PERF_EN
   always_ff @(posedge CLK) begin
      if (RST) PERF_CNT <= '0;
      else if (Q_VLD && Q_RDY && PERF_CNT != 16'hFFFF) PERF_CNT <= PERF_CNT + 16'd1;
   end
`else
   assign PERF_CNT = 16'h0000;
`endif
endmodule

// File: tb/tb_and_reduce_pipe.sv
// tb_and_reduce_pipe: self-checking bench for and_reduce_pipe (16x2 and 5x1 configurations).
module tb_and_reduce_pipe;
   logic        clk = 0, rst = 1, in_vld = 0, q_rdy = 0, mode = 0, vld5 = 0;
   logic [31:0] in = '0;
   logic [4:0]  in5 = '0;
   logic        in_rdy, q_vld, rdy5, qv5;
   logic [1:0]  q;
   logic [0:0]  q5;
   logic [15:0] perf, perf5;
   int          errs = 0, checks = 0;
   logic [1:0]  sb[$];

   always #5 clk = ~clk;

   and_reduce_pipe #(.NUM_IN(16), .CHANNELS(2)) dut (
      .CLK(clk), .RST(rst), .IN_VLD(in_vld), .IN_RDY(in_rdy), .IN(in), .MODE(mode),
      .Q_VLD(q_vld), .Q_RDY(q_rdy), .Q(q), .PERF_CNT(perf));
   and_reduce_pipe #(.NUM_IN(5), .CHANNELS(1)) dut5 (
      .CLK(clk), .RST(rst), .IN_VLD(vld5), .IN_RDY(rdy5), .IN(in5), .MODE(mode),
      .Q_VLD(qv5), .Q_RDY(q_rdy), .Q(q5), .PERF_CNT(perf5));

   function automatic logic [1:0] ref16(input logic [31:0] d, input logic m);
      ref16[0] = (d[15:0] == 16'hFFFF) ^ m;
      ref16[1] = (d[31:16] == 16'hFFFF) ^ m;
   endfunction

   function automatic logic [31:0] rnd_beat();
      logic [31:0] d = '1;
      for (int c = 0; c < 2; c++)
         if ($urandom_range(1) == 1) d[c*16 + int'($urandom_range(15))] = 1'b0;
      return d;
   endfunction

   // One clock of stimulus; reports whether the upcoming edge accepts and/or drains a beat.
   task automatic cyc(input logic v, input logic r, input logic [31:0] d, input logic m,
                      output logic acc, output logic drn, output logic [1:0] qo);
      @(negedge clk);
      in_vld = v; q_rdy = r; in = d; mode = m;
      #1;
      acc = v & in_rdy;
      drn = q_vld & r;
      qo  = q;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (q_vld !== 1'b0) begin errs++; $display("FAIL reset_qvld got=%b exp=0", q_vld); end
      checks++; if (q !== 2'b00) begin errs++; $display("FAIL reset_q got=%b exp=00", q); end
      checks++; if (perf !== 16'h0) begin errs++; $display("FAIL reset_perf got=%h exp=0000", perf); end
      checks++; if (qv5 !== 1'b0) begin errs++; $display("FAIL reset_qv5 got=%b exp=0", qv5); end
      rst = 0;
      @(negedge clk); #1;
      checks++; if (in_rdy !== 1'b1) begin errs++; $display("FAIL reset_inrdy got=%b exp=1", in_rdy); end
      checks++; if (rdy5 !== 1'b1) begin errs++; $display("FAIL reset_rdy5 got=%b exp=1", rdy5); end
   endtask

   task automatic test_latency(input logic [31:0] d, input logic m, input logic [1:0] exp);
      logic acc, drn;
      logic [1:0] qq;
      cyc(1, 1, d, m, acc, drn, qq);
      checks++; if (acc !== 1'b1) begin errs++; $display("FAIL lat_accept got=%b exp=1", acc); end
      cyc(0, 1, '0, 0, acc, drn, qq);
      checks++; if (drn !== 1'b0) begin errs++; $display("FAIL lat_early_qvld got=%b exp=0", drn); end
      cyc(0, 1, '0, 0, acc, drn, qq);
      checks++; if (drn !== 1'b1 || qq !== exp)
         begin errs++; $display("FAIL lat_result qvld=%b q=%b exp qvld=1 q=%b", drn, qq, exp); end
      cyc(0, 1, '0, 0, acc, drn, qq);
      checks++; if (drn !== 1'b0) begin errs++; $display("FAIL lat_dup got qvld=%b exp=0", drn); end
   endtask

   task automatic test_pad();
      logic [4:0] pats[2] = '{5'b11111, 5'b01111};
      logic       exps[2] = '{1'b1, 1'b0};
      q_rdy = 1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); vld5 = 1; in5 = pats[k]; mode = 0; #1;
         checks++; if (rdy5 !== 1'b1) begin errs++; $display("FAIL pad_rdy got=%b exp=1", rdy5); end
         @(negedge clk); vld5 = 0; #1;
         checks++; if (qv5 !== 1'b0) begin errs++; $display("FAIL pad_early got=%b exp=0", qv5); end
         @(negedge clk); #1;
         checks++; if (qv5 !== 1'b1 || q5 !== exps[k])
            begin errs++; $display("FAIL pad_result qvld=%b q=%b exp qvld=1 q=%b", qv5, q5, exps[k]); end
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [31:0] beats[4];
      logic        ms[4];
      logic        acc, drn;
      logic [1:0]  qq, e;
      int          i = 0, drains = 0;
      sb.delete();
      for (int k = 0; k < 4; k++) begin beats[k] = rnd_beat(); ms[k] = 1'($urandom_range(1)); end
      for (int c = 0; c < 6; c++) begin
         cyc(i < 4, 0, beats[i < 4 ? i : 0], ms[i < 4 ? i : 0], acc, drn, qq);
         if (acc) begin sb.push_back(ref16(beats[i], ms[i])); i++; end
         if (c >= 2) begin
            checks++; if (q_vld !== 1'b1 || qq !== ref16(beats[0], ms[0]))
               begin errs++; $display("FAIL bp_hold c=%0d qvld=%b q=%b exp q=%b", c, q_vld, qq, ref16(beats[0], ms[0])); end
         end
      end
      checks++; if (i !== 2) begin errs++; $display("FAIL bp_accepted got=%0d exp=2", i); end
      checks++; if (in_rdy !== 1'b0) begin errs++; $display("FAIL bp_inrdy got=%b exp=0", in_rdy); end
      for (int c = 0; c < 20 && drains < 4; c++) begin
         cyc(i < 4, 1, beats[i < 4 ? i : 0], ms[i < 4 ? i : 0], acc, drn, qq);
         if (drn) begin
            e = sb.size() > 0 ? sb.pop_front() : 2'bxx;
            drains++;
            checks++; if (qq !== e) begin errs++; $display("FAIL bp_order n=%0d got=%b exp=%b", drains, qq, e); end
         end
         if (acc) begin sb.push_back(ref16(beats[i], ms[i])); i++; end
      end
      checks++; if (drains !== 4 || sb.size() !== 0)
         begin errs++; $display("FAIL bp_drain got=%0d left=%0d exp=4 left=0", drains, sb.size()); end
      in_vld = 0;
   endtask

   task automatic test_reset_mid();
      logic        acc, drn;
      logic [1:0]  qq;
      logic [31:0] d;
      logic        m;
      int          stale = 0;
      for (int k = 0; k < 2; k++) begin
         cyc(1, 0, rnd_beat(), 0, acc, drn, qq);
         checks++; if (acc !== 1'b1) begin errs++; $display("FAIL mid_fill k=%0d got=%b exp=1", k, acc); end
      end
      @(negedge clk); rst = 1; in_vld = 0;
      @(negedge clk); rst = 0; #1;
      checks++; if (q_vld !== 1'b0) begin errs++; $display("FAIL mid_qvld got=%b exp=0", q_vld); end
      for (int c = 0; c < 6; c++) begin
         cyc(0, 1, '0, 0, acc, drn, qq);
         if (drn) stale++;
      end
      checks++; if (stale !== 0) begin errs++; $display("FAIL mid_stale got=%0d exp=0", stale); end
      d = rnd_beat(); m = 1'($urandom_range(1));
      cyc(1, 1, d, m, acc, drn, qq);
      cyc(0, 1, '0, 0, acc, drn, qq);
      cyc(0, 1, '0, 0, acc, drn, qq);
      checks++; if (drn !== 1'b1 || qq !== ref16(d, m))
         begin errs++; $display("FAIL mid_fresh qvld=%b q=%b exp qvld=1 q=%b", drn, qq, ref16(d, m)); end
      cyc(0, 1, '0, 0, acc, drn, qq);
   endtask

   task automatic test_back_to_back();
      logic        acc, drn, v, r, m;
      logic [1:0]  qq, e;
      logic [31:0] d;
      int          accs = 0, bad = 0, drains = 0;
      sb.delete();
      for (int c = 0; c < 350; c++) begin
         v = c < 50 ? 1'b1 : 1'($urandom_range(1));
         r = c < 50 ? 1'b1 : ($urandom_range(3) != 0);
         if (c >= 340) begin v = 0; r = 1; end
         d = rnd_beat(); m = 1'($urandom_range(1));
         cyc(v, r, d, m, acc, drn, qq);
         if (c < 50 && !acc) bad++;
         if (drn) begin
            e = sb.size() > 0 ? sb.pop_front() : 2'bxx;
            drains++;
            checks++; if (qq !== e) begin errs++; $display("FAIL b2b_data n=%0d got=%b exp=%b", drains, qq, e); end
         end
         if (acc) begin sb.push_back(ref16(d, m)); accs++; end
      end
      checks++; if (bad !== 0) begin errs++; $display("FAIL b2b_throughput stalls=%0d exp=0", bad); end
      checks++; if (drains !== accs || sb.size() !== 0)
         begin errs++; $display("FAIL b2b_count drained=%0d accepted=%0d", drains, accs); end
   endtask

   task automatic test_perf();
`ifdef AND_REDUCE_PIPE_PERF_EN
      @(negedge clk); rst = 1; in_vld = 0;
      @(negedge clk); rst = 0;
      repeat (100) begin @(negedge clk); in_vld = 1; q_rdy = 1; end
      @(negedge clk); in_vld = 0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (perf !== 16'd100) begin errs++; $display("FAIL perf_count got=%0d exp=100", perf); end
      @(negedge clk); in_vld = 1; q_rdy = 1;
      repeat (70000) @(negedge clk);
      in_vld = 0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (perf !== 16'hFFFF) begin errs++; $display("FAIL perf_sat got=%h exp=ffff", perf); end
`else
      repeat (2) @(negedge clk);
      #1;
      checks++; if (perf !== 16'h0000) begin errs++; $display("FAIL perf_off got=%h exp=0000", perf); end
      checks++; if (perf5 !== 16'h0000) begin errs++; $display("FAIL perf5_off got=%h exp=0000", perf5); end
`endif
   endtask

   initial begin
      test_reset();
      test_latency(32'hFFFF_FFFF, 1'b0, 2'b11);
      test_latency(32'hFFFF_7FFF, 1'b1, 2'b01);
      test_pad();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_perf();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/and_reduce_pipe.md
AND_REDUCE_PIPE -- requirements
Module: and_reduce_pipe

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, meaning AND inputs per channel (1..64).
REQ-002 SHALL have parameter CHANNELS, default 1, meaning independent AND channels (1..32).
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 SHALL have port IN_VLD, input, 1, meaning input beat valid.
REQ-006 SHALL have port IN_RDY, output, 1, meaning the block accepts a beat this cycle.
REQ-007 SHALL have port IN, input, CHANNELS*NUM_IN, where channel c uses bits [c*NUM_IN +: NUM_IN].
REQ-008 SHALL have port MODE, input, 1, where 0 selects AND and 1 selects NAND; it is sampled with the beat.
REQ-009 SHALL have port Q_VLD, output, 1, meaning the result is valid.
REQ-010 SHALL have port Q_RDY, input, 1, meaning downstream accepts the result.
REQ-011 SHALL have port Q, output, CHANNELS, the per-channel reduction result.
REQ-012 SHALL have port PERF_CNT, output, 16, the completed-beat counter (see Configuration).

Function
REQ-013 SHALL reduce each channel in a tree of 4-input AND groups; LEVELS = max(1, ceil(log4(NUM_IN))), giving 1 level for NUM_IN=1..4, 2 for 5..16 and 3 for 17..64.
REQ-014 SHALL pad unused group inputs with logic 1 when NUM_IN is not a power of 4.
REQ-015 SHALL register every level; latency from IN accept to Q_VLD is exactly LEVELS cycles with no backpressure.
REQ-016 SHALL carry MODE through the pipeline alongside the data and apply the inversion only at the final level.
REQ-017 SHALL transfer a beat when VLD&RDY are high on a clock edge, for both the input and output handshakes.
REQ-018 SHALL let each stage load when its output register is empty or is draining in the same cycle (ready = !vld_out | ready_next).
REQ-019 SHALL give IN_RDY combinationally from stage-0 readiness, with no combinational path from IN_VLD.
REQ-020 SHALL hold Q and Q_VLD stable while Q_VLD=1 and Q_RDY=0.
REQ-021 SHALL sustain full throughput of one beat per cycle when Q_RDY is held at 1.
REQ-022 SHALL not lose or duplicate a beat when input accept and output drain occur in the same cycle.

Reset
REQ-023 SHALL clear all stage valid bits, Q_VLD, Q and PERF_CNT to 0 on a clock edge with RST=1; IN_RDY=1 in the cycle after reset.
REQ-024 SHALL discard in-flight beats when RST is asserted mid-operation; the first accept after RST deasserts starts a fresh pipeline.

Configuration
REQ-025 SHALL compile the beat counter in only when macro AND_REDUCE_PIPE_PERF_EN is defined: PERF_CNT increments on each Q_VLD&Q_RDY and saturates at 0xFFFF.
REQ-026 SHALL tie PERF_CNT to 16'h0000 and instantiate no counter flops when AND_REDUCE_PIPE_PERF_EN is undefined.

Structure
REQ-027 SHALL place function clog4, the LEVELS computation and the MODE encodings (MODE_AND=0, MODE_NAND=1) in package and_reduce_pkg.
REQ-028 SHALL implement one pipeline level as sub-module and4_stage (parameters: width in groups, CHANNELS), holding the data, mode and valid registers plus the ready logic; the top instantiates LEVELS copies.

Verification
REQ-029 SHALL verify NUM_IN=16, CHANNELS=2, Q_RDY=1: IN=32'hFFFF_FFFF, MODE=0 accepted at cycle 0 -> Q=2'b11, Q_VLD=1 at cycle 2.
REQ-030 SHALL verify the same config with IN=32'hFFFF_7FFF, MODE=1 -> Q=2'b01 (channel 0 NAND=1, channel 1 NAND=0) after 2 cycles.
REQ-031 SHALL verify NUM_IN=5 (padding): IN=5'b11111 -> Q=1, and IN=5'b01111 -> Q=0, each after 2 cycles.
REQ-032 SHALL verify backpressure: Q_RDY=0 while 4 beats are offered -> IN_RDY drops after 2 accepted (LEVELS=2); Q holds the first result; releasing Q_RDY drains the results in order with none lost.
REQ-033 SHALL verify reset mid-flight: RST pulsed one cycle with 2 beats in the pipe -> Q_VLD=0 next cycle and no stale beat ever emerges.
REQ-034 SHALL verify, with AND_REDUCE_PIPE_PERF_EN defined, that 70000 back-to-back beats give PERF_CNT=16'hFFFF, and that PERF_CNT stays 0 when the macro is undefined.
